// File: rtl/audio_pkg.sv
// Shared types and helpers for the audio level detector.
package audio_pkg;

   localparam int unsigned DEF_SAMPLE_W = 16;
   localparam int unsigned MAX_SAMPLE_W = 32;

   typedef enum logic [1:0] {StIdle, StSkip, StShift, StAccum} rx_state_e;

   // Unsigned magnitude of a width-bit two's complement value; the most negative
   // value maps to 2^(width-1), which still fits in width bits.
   function automatic logic [MAX_SAMPLE_W-1:0] abs_u(input logic [MAX_SAMPLE_W-1:0] sample,
                                                     input int unsigned width);
      logic [MAX_SAMPLE_W-1:0] mask;
      logic [MAX_SAMPLE_W-1:0] mag;
      mask = {MAX_SAMPLE_W{1'b1}} >> (MAX_SAMPLE_W - width);
      if (sample[width-1]) mag = (~sample + MAX_SAMPLE_W'(1)) & mask;
      else                 mag = sample & mask;
      return mag;
   endfunction

endpackage

// File: rtl/i2s_rx_left.sv
// I2S left-channel receiver: input synchronizers, edge detect, one-bit-delay skip,
// MSB-first deserializer and truncation detect.
module i2s_rx_left
   import audio_pkg::*;
#(
   parameter int unsigned SAMPLE_W    = DEF_SAMPLE_W,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic                aud_bclk,
   input  logic                aud_adclrck,
   input  logic                aud_adcdat,
   output logic [SAMPLE_W-1:0] sample,
   output logic                sample_stb,
   output logic                trunc_stb
);

   localparam int unsigned CntW = $clog2(SAMPLE_W);

   // Bit order in the sync vectors: {bclk, adclrck, adcdat}
   logic [2:0]          sync_q [SYNC_STAGES];
   logic [2:0]          prev_q;
   logic [2:0]          sync_s;
   logic                bclk_rise, lrck_rise, lrck_fall;
   rx_state_e           state_q, state_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [SAMPLE_W-1:0] shift_q, shift_d;

   assign sync_s    = sync_q[SYNC_STAGES-1];
   assign bclk_rise = sync_s[2] & ~prev_q[2];
   assign lrck_rise = sync_s[1] & ~prev_q[1];
   assign lrck_fall = ~sync_s[1] & prev_q[1];
   assign sample    = shift_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         prev_q  <= '0;
         state_q <= StIdle;
         cnt_q   <= '0;
         shift_q <= '0;
      end else begin
         sync_q[0] <= {aud_bclk, aud_adclrck, aud_adcdat};
         for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         prev_q  <= sync_s;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      sample_stb = 1'b0;
      trunc_stb  = 1'b0;
      if (!enable) begin
         // Partial sample is dropped silently; no truncation report.
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (lrck_fall) state_d = StSkip;
            end
            StSkip: begin
               if (lrck_rise) begin
                  trunc_stb = 1'b1;
                  state_d   = StIdle;
               end else if (bclk_rise) begin
                  cnt_d   = '0;
                  state_d = StShift;
               end
            end
            StShift: begin
               if (lrck_rise) begin
                  trunc_stb = 1'b1;
                  state_d   = StIdle;
               end else if (bclk_rise) begin
                  shift_d = {shift_q[SAMPLE_W-2:0], sync_s[0]};
                  cnt_d   = cnt_q + CntW'(1);
                  if (cnt_q == CntW'(SAMPLE_W - 1)) state_d = StAccum;
               end
            end
            StAccum: begin
               sample_stb = 1'b1;
               state_d    = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

endmodule

// File: rtl/audio_level_detector.sv
// Per-frame mean |sample| of the I2S left channel with hysteretic voice flag.
// Optional AUDIO_PEAK_HOLD_EN adds a per-frame peak magnitude output.
module audio_level_detector
   import audio_pkg::*;
#(
   parameter int unsigned SAMPLE_W    = DEF_SAMPLE_W,
   parameter int unsigned FRAME_LOG2  = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic                aud_bclk,
   input  logic                aud_adclrck,
   input  logic                aud_adcdat,
   input  logic [SAMPLE_W-1:0] thresh,
   input  logic                err_clr,
   output logic [SAMPLE_W-1:0] level,
   output logic                level_valid,
   output logic                voice_active,
   output logic                drop_err
`ifdef AUDIO_PEAK_HOLD_EN
   ,
   output logic [SAMPLE_W-1:0] peak
`endif
);

   localparam int unsigned AccW = SAMPLE_W + FRAME_LOG2;

   logic [SAMPLE_W-1:0]   sample;
   logic                  sample_stb, trunc_stb;
   logic [SAMPLE_W-1:0]   abs_val;
   logic [AccW-1:0]       acc_sum;
   logic [SAMPLE_W-1:0]   new_level;
   logic                  frame_end;

   logic [AccW-1:0]       acc_q, acc_d;
   logic [FRAME_LOG2-1:0] frame_cnt_q, frame_cnt_d;
   logic [SAMPLE_W-1:0]   level_q, level_d;
   logic                  level_valid_q, level_valid_d;
   logic                  voice_q, voice_d;
   logic                  drop_q, drop_d;

   i2s_rx_left #(
      .SAMPLE_W   (SAMPLE_W),
      .SYNC_STAGES(SYNC_STAGES)
   ) u_rx (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .aud_bclk   (aud_bclk),
      .aud_adclrck(aud_adclrck),
      .aud_adcdat (aud_adcdat),
      .sample     (sample),
      .sample_stb (sample_stb),
      .trunc_stb  (trunc_stb)
   );

   assign abs_val   = SAMPLE_W'(abs_u(MAX_SAMPLE_W'(sample), SAMPLE_W));
   assign acc_sum   = acc_q + AccW'(abs_val);
   assign new_level = SAMPLE_W'(acc_sum >> FRAME_LOG2);
   assign frame_end = sample_stb && (frame_cnt_q == '1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q         <= '0;
         frame_cnt_q   <= '0;
         level_q       <= '0;
         level_valid_q <= 1'b0;
         voice_q       <= 1'b0;
         drop_q        <= 1'b0;
      end else begin
         acc_q         <= acc_d;
         frame_cnt_q   <= frame_cnt_d;
         level_q       <= level_d;
         level_valid_q <= level_valid_d;
         voice_q       <= voice_d;
         drop_q        <= drop_d;
      end
   end

   always_comb begin
      acc_d         = acc_q;
      frame_cnt_d   = frame_cnt_q;
      level_d       = level_q;
      level_valid_d = 1'b0;
      voice_d       = voice_q;
      if (sample_stb) begin
         frame_cnt_d = frame_cnt_q + FRAME_LOG2'(1);
         if (frame_end) begin
            acc_d         = '0;
            level_d       = new_level;
            level_valid_d = 1'b1;
            if (new_level >= thresh)             voice_d = 1'b1;
            else if (new_level < (thresh >> 1))  voice_d = 1'b0;
         end else begin
            acc_d = acc_sum;
         end
      end
      // A truncation in the same cycle as err_clr keeps the flag set.
      if (trunc_stb)    drop_d = 1'b1;
      else if (err_clr) drop_d = 1'b0;
      else              drop_d = drop_q;
   end

   assign level        = level_q;
   assign level_valid  = level_valid_q;
   assign voice_active = voice_q;
   assign drop_err     = drop_q;

`ifdef AUDIO_PEAK_HOLD_EN
   logic [SAMPLE_W-1:0] max_q, max_d, peak_q, peak_d, run_max;

   assign run_max = (abs_val > max_q) ? abs_val : max_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         max_q  <= '0;
         peak_q <= '0;
      end else begin
         max_q  <= max_d;
         peak_q <= peak_d;
      end
   end

   always_comb begin
      max_d  = max_q;
      peak_d = peak_q;
      if (sample_stb) begin
         if (frame_end) begin
            peak_d = run_max;
            max_d  = '0;
         end else begin
            max_d = run_max;
         end
      end
   end

   assign peak = peak_q;
`endif

endmodule

// File: tb/tb_audio_level_detector.sv
// Directed bench for audio_level_detector with a 4-sample frame.
module tb_audio_level_detector;

   localparam int unsigned SW  = 16;
   localparam int unsigned FL2 = 2;
   localparam int unsigned SYN = 2;
   localparam int          HB  = 43;  // bclk half period, deliberately not a clk multiple

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          enable = 1'b0;
   logic          aud_bclk = 1'b0;
   logic          aud_adclrck = 1'b1;
   logic          aud_adcdat = 1'b0;
   logic [SW-1:0] thresh = '0;
   logic          err_clr = 1'b0;
   logic [SW-1:0] level;
   logic          level_valid;
   logic          voice_active;
   logic          drop_err;
`ifdef AUDIO_PEAK_HOLD_EN
   logic [SW-1:0] peak;
`endif

   audio_level_detector #(
      .SAMPLE_W   (SW),
      .FRAME_LOG2 (FL2),
      .SYNC_STAGES(SYN)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .aud_bclk    (aud_bclk),
      .aud_adclrck (aud_adclrck),
      .aud_adcdat  (aud_adcdat),
      .thresh      (thresh),
      .err_clr     (err_clr),
      .level       (level),
      .level_valid (level_valid),
      .voice_active(voice_active),
      .drop_err    (drop_err)
`ifdef AUDIO_PEAK_HOLD_EN
      ,
      .peak        (peak)
`endif
   );

   always #10 clk = ~clk;

   int  n_cmp  = 0;
   int  n_fail = 0;
   int  lv_count = 0;
   time lv_time = 0;
   time left_last_rise_t = 0;

   always @(negedge clk) begin
      if (level_valid) begin
         lv_count = lv_count + 1;
         lv_time  = $time;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic i2s_half(input logic lr, input logic [SW-1:0] data, input int nbits,
                           input bit pad);
      aud_adclrck = lr;
      #HB aud_bclk = 1'b1;
      #HB aud_bclk = 1'b0;
      for (int i = 0; i < nbits; i++) begin
         aud_adcdat = data[SW-1-i];
         #HB aud_bclk = 1'b1;
         if (!lr) left_last_rise_t = $time;
         #HB aud_bclk = 1'b0;
      end
      if (pad) begin
         #HB aud_bclk = 1'b1;
         #HB aud_bclk = 1'b0;
      end
   endtask

   task automatic send_sample(input logic [SW-1:0] s);
      i2s_half(1'b0, s, SW, 1'b1);
      i2s_half(1'b1, SW'($urandom), SW, 1'b1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (4) @(posedge clk);
   endtask

   typedef struct {
      logic [3:0][SW-1:0] s;
      logic [SW-1:0]      thr;
      logic [SW-1:0]      exp_level;
      logic               exp_voice;
   } vec_t;

   vec_t vecs[12];

   initial begin
      int lv0;
      time lat;

      vecs[0]  = '{s: {16'(-3000), 16'(3000), 16'(-1000), 16'(1000)}, thr: 2000, exp_level: 2000, exp_voice: 1};
      vecs[1]  = '{s: {16'h8000, 16'h8000, 16'h8000, 16'h8000}, thr: 2000, exp_level: 16'h8000, exp_voice: 1};
      vecs[2]  = '{s: {16'(2500), 16'(-2500), 16'(3000), 16'(2000)}, thr: 2000, exp_level: 2500, exp_voice: 1};
      vecs[3]  = '{s: {16'(2000), 16'(1000), 16'(-1500), 16'(1500)}, thr: 2000, exp_level: 1500, exp_voice: 1};
      vecs[4]  = '{s: {16'(-900), 16'(900), 16'(-900), 16'(900)}, thr: 2000, exp_level: 900, exp_voice: 0};
      vecs[5]  = '{s: {16'(1400), 16'(1000), 16'(-1200), 16'(1200)}, thr: 2000, exp_level: 1200, exp_voice: 0};
      vecs[6]  = '{s: {16'(3), 16'(3), 16'(2), 16'(1)}, thr: 2000, exp_level: 2, exp_voice: 0};
      vecs[7]  = '{s: {16'(0), 16'(0), 16'(0), 16'(0)}, thr: 0, exp_level: 0, exp_voice: 1};
      vecs[8]  = '{s: {16'(-50), 16'(50), 16'(-50), 16'(50)}, thr: 100, exp_level: 50, exp_voice: 1};
      vecs[9]  = '{s: {16'(-49), 16'(49), 16'(-49), 16'(49)}, thr: 100, exp_level: 49, exp_voice: 0};
      vecs[10] = '{s: {16'(-32767), 16'(32767), 16'(-32767), 16'(32767)}, thr: 100, exp_level: 32767, exp_voice: 1};
      vecs[11] = '{s: {16'(-1), 16'(-1), 16'(-1), 16'(-1)}, thr: 2, exp_level: 1, exp_voice: 1};

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_level", 32'(level), 0);
      check("reset_level_valid", 32'(level_valid), 0);
      check("reset_voice", 32'(voice_active), 0);
      check("reset_drop", 32'(drop_err), 0);
      do_reset();
      enable = 1'b1;

      // Table-driven frames, back to back
      for (int v = 0; v < 12; v++) begin
         thresh = vecs[v].thr;
         lv0 = lv_count;
         for (int k = 0; k < 4; k++) send_sample(vecs[v].s[k]);
         @(negedge clk);
         check($sformatf("v%0d_level", v), 32'(level), 32'(vecs[v].exp_level));
         check($sformatf("v%0d_voice", v), 32'(voice_active), 32'(vecs[v].exp_voice));
         check($sformatf("v%0d_pulses", v), 32'(lv_count - lv0), 1);
         if (v == 0) begin
            lat = lv_time - left_last_rise_t;
            check("latency_le_bound", 32'(lat <= time'((SYN + 3) * 20 + 10)), 1);
         end
      end
      check("no_drop_after_table", 32'(drop_err), 0);

      // Truncated sample: not counted, drop_err sticky until err_clr
      do_reset();
      thresh = 2000;
      lv0 = lv_count;
      send_sample(16'(400));
      send_sample(16'(-800));
      i2s_half(1'b0, 16'h7fff, 7, 1'b0);
      i2s_half(1'b1, SW'($urandom), SW, 1'b1);
      @(negedge clk);
      check("trunc_drop_set", 32'(drop_err), 1);
      send_sample(16'(1200));
      @(negedge clk);
      check("trunc_no_early_frame", 32'(lv_count - lv0), 0);
      send_sample(16'(-1600));
      @(negedge clk);
      check("trunc_frame_pulses", 32'(lv_count - lv0), 1);
      check("trunc_frame_level", 32'(level), 1000);
      check("trunc_drop_sticky", 32'(drop_err), 1);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      @(negedge clk);
      check("err_clr_clears", 32'(drop_err), 0);

      // enable dropped mid-SHIFT: partial sample discarded, frame resumes
      do_reset();
      lv0 = lv_count;
      send_sample(16'(100));
      send_sample(16'(200));
      i2s_half(1'b0, 16'h7abc, 5, 1'b0);
      enable = 1'b0;
      repeat (100) @(posedge clk);
      #1 enable = 1'b1;
      i2s_half(1'b1, SW'($urandom), SW, 1'b1);
      send_sample(16'(300));
      @(negedge clk);
      check("en_no_early_frame", 32'(lv_count - lv0), 0);
      send_sample(16'(-400));
      @(negedge clk);
      check("en_frame_pulses", 32'(lv_count - lv0), 1);
      check("en_frame_level", 32'(level), 250);
      check("en_no_drop", 32'(drop_err), 0);

      // Reset mid-frame clears outputs at once and restarts framing
      send_sample(16'(5000));
      send_sample(16'(5000));
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_level", 32'(level), 0);
      check("midrst_voice", 32'(voice_active), 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (4) @(posedge clk);
      lv0 = lv_count;
      send_sample(16'(40));
      send_sample(16'(80));
      send_sample(16'(-120));
      send_sample(16'(160));
      @(negedge clk);
      check("midrst_frame_pulses", 32'(lv_count - lv0), 1);
      check("midrst_frame_level", 32'(level), 100);

`ifdef AUDIO_PEAK_HOLD_EN
      do_reset();
      send_sample(16'(100));
      send_sample(16'(-5000));
      send_sample(16'(300));
      send_sample(16'(20));
      @(negedge clk);
      check("peak_frame1", 32'(peak), 5000);
      for (int k = 0; k < 4; k++) send_sample(16'(10));
      @(negedge clk);
      check("peak_frame2", 32'(peak), 10);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #20000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/audio_level_detector.md
Name: audio_level_detector

Overview:
- Consumes the serial ADC stream of the audio codec (I2S, left channel only) and computes a per-frame mean absolute amplitude.
- Produces a voice-activity flag with hysteresis.
- Sits between the codec pins and the Nios PIOs that drive game control, replacing software sample polling.
- Runs on the 50 MHz system clock; codec clocks are treated as asynchronous data inputs.

Parameters:
- SAMPLE_W, 16, bits per codec sample (two's complement).
- FRAME_LOG2, 8, log2 of samples per frame (default 256 samples).
- SYNC_STAGES, 2, synchronizer depth on aud_bclk/aud_adclrck/aud_adcdat.

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  1 = capture and accumulate; 0 = hold outputs, FSM to IDLE.
- aud_bclk  in  1  codec bit clock (asynchronous).
- aud_adclrck  in  1  codec ADC LR clock (low = left channel).
- aud_adcdat  in  1  codec ADC serial data.
- thresh  in  SAMPLE_W  activity threshold from PIO (unsigned).
- err_clr  in  1  clears drop_err.
- level  out  SAMPLE_W  last frame mean |sample|.
- level_valid  out  1  one-cycle pulse when level updates.
- voice_active  out  1  hysteretic activity flag.
- drop_err  out  1  sticky: a sample was truncated.

Behaviour:
- Reset values: level = 0, level_valid = 0, voice_active = 0, drop_err = 0; accumulator and counters = 0; FSM = IDLE.
- Input conditioning:
  - All three codec inputs pass through SYNC_STAGES flip-flops.
  - Rise/fall detection uses one extra register on the synchronized signals.
  - Bit sampling uses the synchronized bclk rising edge with the synchronized adcdat.
- FSM:
  - IDLE: wait for adclrck falling edge (enable = 1) -> SKIP.
  - SKIP: discard the first bclk rise (I2S one-bit delay) -> SHIFT; bit counter = 0.
  - SHIFT: on each bclk rise, shift adcdat in MSB-first and increment the counter. After SAMPLE_W bits -> ACCUM.
  - ACCUM: single cycle. Computes abs = sample[W-1] ? -sample : sample in SAMPLE_W unsigned bits (−2^(W−1) -> 2^(W−1), no overflow at W bits). Then acc += abs, frame_cnt += 1 -> IDLE.
- Accumulator width is SAMPLE_W+FRAME_LOG2; it cannot overflow.
- Frame end, when frame_cnt wraps from 2^FRAME_LOG2−1 to 0 in ACCUM:
  - level <= (acc+abs) >> FRAME_LOG2.
  - acc <= 0.
  - level_valid = 1 in the following cycle only.
- Hysteresis, evaluated in the same cycle level updates, using the new level:
  - Set voice_active if level >= thresh.
  - Clear voice_active if level < (thresh >> 1).
  - Otherwise hold.
- Truncation: an adclrck rising edge while in SKIP or SHIFT aborts the sample. The sample is not accumulated, drop_err <= 1, FSM -> IDLE.
- If err_clr and a new truncation coincide, the set wins.
- enable deassert mid-sample: FSM -> IDLE next cycle, partial sample discarded, acc and frame_cnt held (resume on re-enable), no drop_err.
- Latency: last data bit bclk edge to level_valid ≤ SYNC_STAGES + 3 clk.
- Reset mid-frame: everything returns to reset values immediately; the first post-reset sample starts at the next adclrck fall.

Optional Feature:
- Macro: AUDIO_PEAK_HOLD_EN.
- Defined:
  - Adds output peak [SAMPLE_W] holding the maximum abs within the last completed frame.
  - peak updates alongside level, with the same level_valid pulse.
  - Internal running max resets to 0 at frame end; reset value is 0.
- Undefined: no peak port and no max register; all other behaviour identical.

Decomposition:
- Package audio_pkg:
  - Constant for default SAMPLE_W.
  - FSM state typedef (IDLE, SKIP, SHIFT, ACCUM).
  - Function abs_u(sample) returning unsigned magnitude.
- Sub-module i2s_rx_left:
  - Contains the synchronizers, edge detect, SKIP/SHIFT deserializer and truncation detect.
  - Outputs sample, sample_stb and trunc_stb.
  - Parent holds the accumulator, framing, hysteresis and peak.

Test Plan:
- FRAME_LOG2=2, four left samples +1000, −1000, +3000, −3000, right channel random -> level=2000, exactly one level_valid pulse, right-channel data never affects level.
- Sample 16'h8000 alone repeated for a full frame -> level=32768 truncated to W bits = 16'h8000; no accumulator overflow, level exact.
- thresh=2000: frames with level 2500, 1500, 900, 1200 -> voice_active = 1, 1, 0, 0.
- adclrck rises after 7 bits of a left sample -> drop_err=1, frame_cnt unchanged; err_clr pulse -> drop_err=0.
- enable dropped mid-SHIFT for 100 clk, then restored -> partial sample discarded, frame completes with the remaining samples, no drop_err.
- With AUDIO_PEAK_HOLD_EN: samples 100, −5000, 300, 20 -> peak=5000 at level_valid; next frame of all 10 -> peak=10.
